// File: rtl/mem_arbiter.sv
// Two-requester main-memory arbiter: I-cache block fills, D-cache block fills and
// D-cache single-word write-through, with a starve flag so D cannot win twice while I waits.
module mem_arbiter #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [15:0]       d_wdata,
  input  logic              mem_rdata_valid,
  input  logic [15:0]       mem_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              i_grant,
  output logic              d_grant,
  output logic              i_data_valid,
  output logic              d_data_valid,
  output logic [2:0]        fill_word,
  output logic [15:0]       fill_data,
  output logic              i_done,
  output logic              d_done
);

  typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;

  localparam logic [2:0]        LAST      = 3'(BLOCK_WORDS - 1);
  localparam logic [ADDR_W-1:0] FILL_MASK = ~ADDR_W'(15);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [15:0]       wdata_q;
  logic [2:0]        issue_cnt;
  logic [2:0]        ret_cnt;
  logic              issuing;
  logic              starve;

  logic fill_state;
  logic ret_fire;
  logic last_ret;

  assign fill_state = (state == I_FILL) || (state == D_FILL);
  assign ret_fire   = fill_state && mem_rdata_valid;
  assign last_ret   = ret_fire && (ret_cnt == LAST);

  always_comb begin
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if (state == D_WRITE) begin
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = base;
      mem_wdata = wdata_q;
    end else if (fill_state && issuing) begin
      mem_en   = 1'b1;
      mem_addr = base + ADDR_W'({issue_cnt, 1'b0});
    end
    i_data_valid = (state == I_FILL) && mem_rdata_valid;
    d_data_valid = (state == D_FILL) && mem_rdata_valid;
    fill_word    = ret_fire ? ret_cnt : '0;
    fill_data    = mem_rdata;
    i_done       = (state == I_FILL) && last_ret;
    d_done       = ((state == D_FILL) && last_ret) || (state == D_WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      i_grant   <= 1'b0;
      d_grant   <= 1'b0;
      base      <= '0;
      wdata_q   <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      issuing   <= 1'b0;
      starve    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          issue_cnt <= '0;
          ret_cnt   <= '0;
          // D wins ties unless it already won last time while I was waiting.
          if (d_req && !(i_req && starve)) begin
            starve  <= i_req;
            d_grant <= 1'b1;
            wdata_q <= d_wdata;
            if (d_we) begin
              state   <= D_WRITE;
              base    <= d_addr & WORD_MASK;
              issuing <= 1'b0;
            end else begin
              state   <= D_FILL;
              base    <= d_addr & FILL_MASK;
              issuing <= 1'b1;
            end
          end else if (i_req) begin
            starve  <= 1'b0;
            i_grant <= 1'b1;
            state   <= I_FILL;
            base    <= i_addr & FILL_MASK;
            issuing <= 1'b1;
          end
        end
        I_FILL, D_FILL: begin
          if (issuing) begin
            issue_cnt <= issue_cnt + 3'd1;
            if (issue_cnt == LAST) issuing <= 1'b0;
          end
          if (mem_rdata_valid) begin
            ret_cnt <= ret_cnt + 3'd1;
            if (ret_cnt == LAST) begin
              state   <= IDLE;
              i_grant <= 1'b0;
              d_grant <= 1'b0;
            end
          end
        end
        D_WRITE: begin
          state   <= IDLE;
          d_grant <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single-cycle vector table followed by fill/arbitration
// sequences driven against a 4-cycle-latency memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        mem_rdata_valid;
  logic [15:0] mem_rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        i_grant;
  logic        d_grant;
  logic        i_data_valid;
  logic        d_data_valid;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        i_done;
  logic        d_done;

  always #5 clk = ~clk;

  mem_arbiter #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .i_grant(i_grant), .d_grant(d_grant),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
    .fill_word(fill_word), .fill_data(fill_data),
    .i_done(i_done), .d_done(d_done)
  );

  typedef struct packed {
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        i_grant;
    logic        d_grant;
    logic        i_dv;
    logic        d_dv;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        i_done;
    logic        d_done;
  } out_t;

  typedef struct {
    string       name;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        mv;
    logic [15:0] mrd;
    out_t        exp;
  } vec_t;

  typedef struct { int cyc; logic wr; logic [1:0] owner; logic [15:0] addr; logic [15:0] wdata; } iss_t;
  typedef struct { int cyc; logic side; logic [2:0] word; logic [15:0] data; } ret_t;
  typedef struct { int cyc; logic side; } done_t;

  iss_t  iss_q[$];
  ret_t  ret_q[$];
  done_t done_q[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  out_t        o;
  logic        pv[8];
  logic [15:0] pd[8];
  vec_t        vecs[11];

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic out_t o_idle(input logic [15:0] fd);
    out_t e;
    e = '0;
    e.fill_data = fd;
    return e;
  endfunction

  function automatic out_t o_wr(input logic [15:0] a, input logic [15:0] d);
    out_t e;
    e = '0;
    e.mem_en = 1'b1; e.mem_wr = 1'b1; e.mem_addr = a; e.mem_wdata = d;
    e.d_grant = 1'b1; e.d_done = 1'b1;
    return e;
  endfunction

  function automatic vec_t mk(input string n, input logic r, input logic ir, input logic [15:0] ia,
                              input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] dd,
                              input logic mv, input logic [15:0] md, input out_t e);
    vec_t v;
    v.name = n; v.rst = r; v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = dw;
    v.d_addr = da; v.d_wdata = dd; v.mv = mv; v.mrd = md; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One clock cycle: present memory return, sample outputs, log traffic, advance the memory pipe.
  task automatic tick(input logic fmv, input logic [15:0] fmd);
    iss_t ir;
    ret_t rr;
    done_t dr;
    mem_rdata_valid = pv[0] | fmv;
    mem_rdata = fmv ? fmd : pd[0];
    #1;
    o = {mem_en, mem_wr, mem_addr, mem_wdata, i_grant, d_grant, i_data_valid, d_data_valid,
         fill_word, fill_data, i_done, d_done};
    if (!rst && o.mem_en === 1'b1) begin
      ir.cyc = cyc; ir.wr = o.mem_wr; ir.owner = {o.i_grant, o.d_grant};
      ir.addr = o.mem_addr; ir.wdata = o.mem_wdata;
      iss_q.push_back(ir);
      if (o.mem_wr === 1'b0) begin
        pv[4] = 1'b1;
        pd[4] = mem_fn(o.mem_addr);
      end
    end
    if (o.i_dv === 1'b1) begin
      rr.cyc = cyc; rr.side = 1'b0; rr.word = o.fill_word; rr.data = o.fill_data;
      ret_q.push_back(rr);
    end
    if (o.d_dv === 1'b1) begin
      rr.cyc = cyc; rr.side = 1'b1; rr.word = o.fill_word; rr.data = o.fill_data;
      ret_q.push_back(rr);
    end
    if (o.i_done === 1'b1) begin dr.cyc = cyc; dr.side = 1'b0; done_q.push_back(dr); end
    if (o.d_done === 1'b1) begin dr.cyc = cyc; dr.side = 1'b1; done_q.push_back(dr); end
    @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      pv[k] = pv[k+1];
      pd[k] = pd[k+1];
    end
    pv[7] = 1'b0;
    pd[7] = '0;
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        pv[k] = 1'b0;
        pd[k] = '0;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_done(input logic is_d, input string name, output int dc);
    int c;
    dc = -1;
    for (int n = 0; n < 60; n++) begin
      c = cyc;
      tick(1'b0, 16'h0);
      if ((is_d ? o.d_done : o.i_done) === 1'b1) begin
        dc = c;
        break;
      end
    end
    if (dc < 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got=no_done exp=done", name);
    end
  endtask

  task automatic check_fill(input logic is_d, input logic [15:0] base, input int t0, input string name);
    iss_t ir;
    ret_t rr;
    done_t dr;
    logic [15:0] a;
    for (int k = 0; k < 8; k++) begin
      a = base + 16'(2 * k);
      if (iss_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s_iss%0d got=none exp=%h", name, k, a);
      end else begin
        ir = iss_q.pop_front();
        chk($sformatf("%s_iss%0d", name, k), {32'(ir.cyc), ir.wr, ir.owner, ir.addr},
            {32'(t0 + k), 1'b0, (is_d ? 2'b01 : 2'b10), a});
      end
    end
    for (int k = 0; k < 8; k++) begin
      a = base + 16'(2 * k);
      if (ret_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s_ret%0d got=none exp=%h", name, k, mem_fn(a));
      end else begin
        rr = ret_q.pop_front();
        chk($sformatf("%s_ret%0d", name, k), {32'(rr.cyc), rr.side, rr.word, rr.data},
            {32'(t0 + 4 + k), is_d, 3'(k), mem_fn(a)});
      end
    end
    if (done_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_done got=none exp=%0d", name, t0 + 11);
    end else begin
      dr = done_q.pop_front();
      chk({name, "_done"}, {32'(dr.cyc), dr.side}, {32'(t0 + 11), is_d});
    end
  endtask

  task automatic check_write(input logic [15:0] a, input logic [15:0] d, input int t, input string name);
    iss_t ir;
    done_t dr;
    if (iss_q.size() == 0 || done_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s got=none exp=write_at_%0d", name, t);
    end else begin
      ir = iss_q.pop_front();
      dr = done_q.pop_front();
      chk({name, "_iss"}, {32'(ir.cyc), ir.wr, ir.owner, ir.addr, ir.wdata}, {32'(t), 1'b1, 2'b01, a, d});
      chk({name, "_done"}, {32'(dr.cyc), dr.side}, {32'(t), 1'b1});
    end
  endtask

  task automatic clear_logs();
    iss_q.delete();
    ret_q.delete();
    done_q.delete();
  endtask

  initial begin
    int t;
    int dc;
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata_valid = 1'b0; mem_rdata = '0;
    for (int k = 0; k < 8; k++) begin
      pv[k] = 1'b0;
      pd[k] = '0;
    end

    vecs[0]  = mk("reset_state",   0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    0, 16'h0,    o_idle(16'h0));
    vecs[1]  = mk("idle_rvalid",   0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    1, 16'h1111, o_idle(16'h1111));
    vecs[2]  = mk("wr_req",        0, 0, 16'h0,    1, 1, 16'h4003, 16'hBEEF, 0, 16'h0,    o_idle(16'h0));
    vecs[3]  = mk("wr_issue",      0, 0, 16'h0,    1, 1, 16'h4003, 16'hBEEF, 0, 16'h0,    o_wr(16'h4002, 16'hBEEF));
    vecs[4]  = mk("wr_after",      0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    0, 16'h0,    o_idle(16'h0));
    vecs[5]  = mk("rst_prio",      1, 0, 16'h0,    1, 1, 16'h4003, 16'hBEEF, 0, 16'h0,    o_idle(16'h0));
    vecs[6]  = mk("rst_prio_next", 0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    0, 16'h0,    o_idle(16'h0));
    vecs[7]  = mk("wr2_req",       0, 0, 16'h0,    1, 1, 16'h7FFF, 16'h1234, 0, 16'h0,    o_idle(16'h0));
    vecs[8]  = mk("wr2_issue",     0, 0, 16'h0,    1, 1, 16'h7FFF, 16'h1234, 0, 16'h0,    o_wr(16'h7FFE, 16'h1234));
    vecs[9]  = mk("idle_rvalid2",  0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    1, 16'hABCD, o_idle(16'hABCD));
    vecs[10] = mk("idle",          0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    0, 16'h0,    o_idle(16'h0));

    tick(1'b0, 16'h0);
    tick(1'b0, 16'h0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst; i_req = vecs[i].i_req; i_addr = vecs[i].i_addr;
      d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
      tick(vecs[i].mv, vecs[i].mrd);
      chk(vecs[i].name, 96'(o), 96'(vecs[i].exp));
    end
    rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
    clear_logs();

    // I fill alone, with a stray return pulse in the request cycle
    i_req = 1'b1; i_addr = 16'h1236;
    t = cyc;
    tick(1'b1, 16'h7777);
    chk("s1_idle_pulse", {o.i_dv, o.d_dv, o.mem_en, o.i_grant}, 4'b0000);
    wait_done(1'b0, "s1_wait", dc);
    i_req = 1'b0;
    tick(1'b0, 16'h0);
    chk("s1_idle_after", {o.i_grant, o.d_grant, o.mem_en}, 3'b000);
    check_fill(1'b0, 16'h1230, t + 1, "s1");
    chk("s1_no_extra", {32'(iss_q.size()), 32'(ret_q.size()), 32'(done_q.size())}, 96'd0);

    // Simultaneous requests: D fill, then I fill; D re-request waits for i_done
    clear_logs();
    i_req = 1'b1; i_addr = 16'h2000; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h3008;
    t = cyc;
    tick(1'b0, 16'h0);
    wait_done(1'b1, "s2_d1_wait", dc);
    d_req = 1'b0;
    repeat (4) tick(1'b0, 16'h0);
    d_req = 1'b1; d_addr = 16'h3010;
    wait_done(1'b0, "s2_i_wait", dc);
    i_req = 1'b0;
    wait_done(1'b1, "s2_d2_wait", dc);
    d_req = 1'b0;
    tick(1'b0, 16'h0);
    check_fill(1'b1, 16'h3000, t + 1, "s2_d1");
    check_fill(1'b0, 16'h2000, t + 14, "s2_i");
    check_fill(1'b1, 16'h3010, t + 27, "s2_d2");

    // I waiting across two back-to-back D write-throughs
    clear_logs();
    i_req = 1'b1; i_addr = 16'h444C; d_req = 1'b1; d_we = 1'b1; d_addr = 16'h5001; d_wdata = 16'h1111;
    t = cyc;
    tick(1'b0, 16'h0);
    wait_done(1'b1, "s3_w1_wait", dc);
    d_addr = 16'h5005; d_wdata = 16'h2222;
    wait_done(1'b0, "s3_i_wait", dc);
    i_req = 1'b0;
    wait_done(1'b1, "s3_w2_wait", dc);
    d_req = 1'b0; d_we = 1'b0;
    tick(1'b0, 16'h0);
    check_write(16'h5000, 16'h1111, t + 1, "s3_w1");
    check_fill(1'b0, 16'h4440, t + 3, "s3_i");
    check_write(16'h5004, 16'h2222, t + 16, "s3_w2");

    // Reset on the 3rd return of a D fill, then a clean fill
    clear_logs();
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h6000;
    tick(1'b0, 16'h0);
    repeat (6) tick(1'b0, 16'h0);
    rst = 1'b1;
    tick(1'b0, 16'h0);
    chk("s4_third_ret", {o.d_dv, o.fill_word, o.d_done}, {1'b1, 3'd2, 1'b0});
    rst = 1'b0; d_req = 1'b0;
    tick(1'b0, 16'h0);
    chk("s4_rst_outputs", 96'(o), 96'd0);
    repeat (3) tick(1'b0, 16'h0);
    chk("s4_no_done", 96'(done_q.size()), 96'd0);
    clear_logs();
    d_req = 1'b1; d_addr = 16'h6010;
    t = cyc;
    tick(1'b0, 16'h0);
    wait_done(1'b1, "s4_wait", dc);
    d_req = 1'b0;
    tick(1'b0, 16'h0);
    check_fill(1'b1, 16'h6010, t + 1, "s4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: BLOCK_WORDS, 8, 16-bit words per cache-block fill (16-byte block).
REQ-002 Parameter: ADDR_W, 16, byte-address width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 i_req  in  1  I-cache miss: block fill requested; held until i_done.
REQ-006 i_addr  in  ADDR_W  I-side miss byte address; bits [3:0] ignored.
REQ-007 d_req  in  1  D-cache request (fill or write-through); held until d_done.
REQ-008 d_we  in  1  D-side: 1 = single-word write-through, 0 = block fill.
REQ-009 d_addr  in  ADDR_W  D-side byte address; bit 0 ignored.
REQ-010 d_wdata  in  16  D-side write data.
REQ-011 mem_rdata_valid  in  1  main memory read word returning this cycle.
REQ-012 mem_rdata  in  16  main memory read data.
REQ-013 mem_en  out  1  issue one memory access this cycle.
REQ-014 mem_wr  out  1  issued access is a write.
REQ-015 mem_addr  out  ADDR_W  issued access byte address.
REQ-016 mem_wdata  out  16  issued write data.
REQ-017 i_grant / d_grant  out  1 each  side currently owns memory.
REQ-018 i_data_valid / d_data_valid  out  1 each  fill word for that side on fill_data.
REQ-019 fill_word  out  3  index (0..7) of the fill word being delivered.
REQ-020 fill_data  out  16  fill word; equals mem_rdata.
REQ-021 i_done / d_done  out  1 each  one-cycle pulse: transaction complete.

Function
REQ-022 FSM states: IDLE, I_FILL, D_FILL, D_WRITE; exactly one active; grants registered, i_grant=1 only in I_FILL, d_grant=1 only in D_FILL/D_WRITE.
REQ-023 IDLE arbitration (one decision per cycle): d_req only -> D; i_req only -> I; both -> D unless starve flag set, then I; neither -> stay IDLE.
REQ-024 Starve flag set when a D transaction is granted while i_req=1; cleared when I is granted; prevents two consecutive D grants while I waits.
REQ-025 Grant decided in IDLE cycle N; owning state entered and grant high from cycle N+1; no memory access issued in IDLE.
REQ-026 D side chooses D_WRITE if d_we=1, else D_FILL; d_we/d_addr/d_wdata sampled at grant.
REQ-027 Fill base = addr & 0xFFF0, latched at grant; 3-bit issue counter and 3-bit return counter cleared at grant.
REQ-028 Fill issue: mem_en=1, mem_wr=0, mem_addr=base+2*issue_cnt for first BLOCK_WORDS cycles of the fill state, one per cycle, back-to-back; mem_en=0 after the 8th issue.
REQ-029 Fill return: each cycle mem_rdata_valid=1 in a fill state -> owning side's data_valid=1, fill_word=return counter, fill_data=mem_rdata (combinational); return counter increments.
REQ-030 Issue and return in same cycle both counted; memory latency (nominal 4 cycles) not assumed by the arbiter.
REQ-031 On the 8th return: owning done pulses that cycle; state returns to IDLE next cycle; new arbitration in that IDLE cycle.
REQ-032 D_WRITE lasts one cycle: mem_en=1, mem_wr=1, mem_addr=d_addr&0xFFFE, mem_wdata=d_wdata, d_done=1; then IDLE.
REQ-033 mem_rdata_valid ignored in IDLE and D_WRITE: no data_valid, no counter change.
REQ-034 Requester dropping req mid-transaction is ignored; transaction runs to done.
REQ-035 Minimum issue-to-issue gap between transactions: one IDLE cycle.
REQ-036 mem_wr=0, mem_wdata=0 whenever not in D_WRITE; fill_word=0 when no data_valid.

Reset
REQ-037 rst=1 at a clock edge -> IDLE, counters 0, starve flag 0, latched base 0, all grants/done/data_valid/mem_en 0, from the following cycle.
REQ-038 Reset mid-fill abandons the transaction with no done pulse; main memory shares rst, so in-flight returns do not occur.
REQ-039 Reset has priority over any simultaneous request.

Verification
REQ-040 i_req, i_addr=0x1236, 4-cycle memory -> i_grant next cycle; addresses 0x1230..0x123E on 8 consecutive cycles; 8 i_data_valid with fill_word 0..7; i_done on 8th return; IDLE next cycle.
REQ-041 d_req, d_we=1, d_addr=0x4003, d_wdata=0xBEEF -> one cycle mem_wr=1, mem_addr=0x4002, mem_wdata=0xBEEF, d_done same cycle.
REQ-042 i_req and d_req (fill) same IDLE cycle, both held -> D fill first, then I fill; d_req reasserted during I fill -> D only after i_done.
REQ-043 I waiting, D issues two back-to-back write-throughs -> first D write, then I fill (starve flag), then second D write.
REQ-044 rst=1 at 3rd return of a D fill -> all outputs 0 next cycle, no d_done; later request completes normally with counters from 0.
REQ-045 mem_rdata_valid pulsed in IDLE -> no data_valid output, next fill delivers exactly 8 words indexed 0..7.
